user_ip_apb_bridge: RTL and testbench

USER_IP_APB_BRIDGE -- requirements
Module: user_ip_apb_bridge

---
 rtl/user_ip_apb_bridge_if.sv | 22 ++
 rtl/user_ip_apb_bridge.sv | 173 +++++++++++++++++
 tb/tb_user_ip_apb_bridge.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/user_ip_apb_bridge_if.sv
// APB4 signal bundle between the bridge (master) and the user IP wrapper (slave).
interface apb4_if;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready;
   logic [31:0] prdata;

   modport master (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata
   );

   modport slave (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata
   );
endinterface

// File: rtl/user_ip_apb_bridge.sv
// Core memory-bus to APB4 bridge with a local user IP select register.
// Define USER_IP_BRIDGE_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without pready.
module user_ip_apb_bridge #(
   parameter int          TIMEOUT_CYCLES   = 255,
   parameter logic [11:0] SEL_REG_OFFS     = 12'hFFC,
   parameter int          USER_IPSEL_WIDTH = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        mem_valid_i,
   input  logic [31:0]                 mem_addr_i,
   input  logic [31:0]                 mem_wdata_i,
   input  logic [3:0]                  mem_wstrb_i,
   output logic                        mem_ready_o,
   output logic [31:0]                 mem_rdata_o,
   output logic [USER_IPSEL_WIDTH-1:0] sel_o,
   output logic                        timeout_o,
   apb4_if.master                      apb
);

   if (TIMEOUT_CYCLES < 1 || USER_IPSEL_WIDTH < 1 || USER_IPSEL_WIDTH > 32) begin : g_bad_param
      $error("user_ip_apb_bridge: TIMEOUT_CYCLES must be >= 1 and USER_IPSEL_WIDTH in 1..32");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

   state_e                      state_q, state_d;
   logic                        psel_q, psel_d;
   logic                        penable_q, penable_d;
   logic                        pwrite_q, pwrite_d;
   logic [31:0]                 paddr_q, paddr_d;
   logic [31:0]                 pwdata_q, pwdata_d;
   logic [3:0]                  pstrb_q, pstrb_d;
   logic                        ready_q, ready_d;
   logic [31:0]                 rdata_q, rdata_d;
   logic [USER_IPSEL_WIDTH-1:0] sel_q, sel_d;
   logic                        local_hit;
   logic                        is_write;

`ifdef USER_IP_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             tc_hit;
   // Counter holds the index of the current ACCESS cycle, so the last allowed one is TIMEOUT_CYCLES-1.
   assign tc_hit    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign local_hit = (mem_addr_i[11:0] == SEL_REG_OFFS);
   assign is_write  = |mem_wstrb_i;

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      ready_d   = 1'b0;
      rdata_d   = rdata_q;
      sel_d     = sel_q;
`ifdef USER_IP_BRIDGE_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (mem_valid_i) begin
               if (local_hit) begin
                  state_d = RESP;
                  ready_d = 1'b1;
                  rdata_d = 32'(sel_q);
                  if (is_write && mem_wstrb_i[0]) begin
                     sel_d = mem_wdata_i[USER_IPSEL_WIDTH-1:0];
                  end
               end else begin
                  state_d   = SETUP;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  paddr_d   = mem_addr_i;
                  pwdata_d  = mem_wdata_i;
                  pwrite_d  = is_write;
                  pstrb_d   = is_write ? mem_wstrb_i : 4'b0000;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
`ifdef USER_IP_BRIDGE_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         ACCESS: begin
            // pready wins over the terminal count, so a last-cycle response still completes.
            if (apb.pready) begin
               state_d   = RESP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               ready_d   = 1'b1;
               rdata_d   = apb.prdata;
`ifdef USER_IP_BRIDGE_TIMEOUT_EN
            end else if (tc_hit) begin
               state_d   = RESP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               ready_d   = 1'b1;
               rdata_d   = 32'h0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= 32'h0;
         pwdata_q  <= 32'h0;
         pstrb_q   <= 4'h0;
         ready_q   <= 1'b0;
         rdata_q   <= 32'h0;
         sel_q     <= '0;
`ifdef USER_IP_BRIDGE_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
         sel_q     <= sel_d;
`ifdef USER_IP_BRIDGE_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwdata  = pwdata_q;
   assign apb.pstrb   = pstrb_q;
   assign apb.pprot   = 3'b000;
   assign mem_ready_o = ready_q;
   assign mem_rdata_o = rdata_q;
   assign sel_o       = sel_q;

endmodule

// File: tb/tb_user_ip_apb_bridge.sv
// Directed bench for user_ip_apb_bridge: bench plays core and APB slave, scoreboard holds read data and latency.
module tb_user_ip_apb_bridge;

`ifdef USER_IP_BRIDGE_TIMEOUT_EN
   localparam int TO_CYCLES = 4;
`else
   localparam int TO_CYCLES = 255;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_valid_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [3:0]  mem_wstrb_i;
   logic        mem_ready_o;
   logic [31:0] mem_rdata_o;
   logic [3:0]  sel_o;
   logic        timeout_o;

   apb4_if apb_bus ();

   user_ip_apb_bridge #(
      .TIMEOUT_CYCLES   (TO_CYCLES),
      .SEL_REG_OFFS     (12'hFFC),
      .USER_IPSEL_WIDTH (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .mem_valid_i (mem_valid_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_wstrb_i (mem_wstrb_i),
      .mem_ready_o (mem_ready_o),
      .mem_rdata_o (mem_rdata_o),
      .sel_o       (sel_o),
      .timeout_o   (timeout_o),
      .apb         (apb_bus)
   );

   always #5 clk_i = ~clk_i;

   logic [31:0] exp_q[$];
   int          lat_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; drives one core request and acts as APB slave until completion.
   task automatic issue(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int waits, input logic [31:0] slv_rdata,
                        input logic [31:0] exp_rd, input int exp_acc, input bit is_local,
                        input bit exp_to, input bit drop_valid);
      int          setup_n = 0;
      int          access_n = 0;
      bit          done = 1'b0;
      logic        wr = |wstrb;
      logic [31:0] e_rd;
      int          e_lat;
      mem_valid_i = 1'b1;
      mem_addr_i  = addr;
      mem_wdata_i = wdata;
      mem_wstrb_i = wstrb;
      exp_q.push_back(exp_rd);
      lat_q.push_back(is_local ? 1 : exp_acc + 2);
      for (int i = 1; i <= 60 && !done; i++) begin
         @(negedge clk_i);
         if (apb_bus.psel) begin
            chk({name, " paddr"},  apb_bus.paddr, addr);
            chk({name, " pwdata"}, apb_bus.pwdata, wdata);
            chk({name, " pwrite"}, 32'(apb_bus.pwrite), 32'(wr));
            chk({name, " pstrb"},  32'(apb_bus.pstrb), wr ? 32'(wstrb) : 32'h0);
            chk({name, " pprot"},  32'(apb_bus.pprot), 32'h0);
         end
         if (apb_bus.psel && !apb_bus.penable) setup_n++;
         if (apb_bus.psel && apb_bus.penable) begin
            apb_bus.pready = (access_n >= waits);
            apb_bus.prdata = slv_rdata;
            access_n++;
         end else begin
            apb_bus.pready = 1'b0;
         end
         if (mem_ready_o) begin
            done  = 1'b1;
            e_rd  = exp_q.pop_front();
            e_lat = lat_q.pop_front();
            chk({name, " latency"}, 32'(i), 32'(e_lat));
            if (!wr) chk({name, " rdata"}, mem_rdata_o, e_rd);
            chk({name, " timeout"}, 32'(timeout_o), 32'(exp_to));
            chk({name, " resp psel/penable"}, {30'b0, apb_bus.psel, apb_bus.penable}, 32'h0);
            mem_valid_i = 1'b0;
         end
         if (drop_valid && i == 1) mem_valid_i = 1'b0;
      end
      if (!done) begin
         chk({name, " ready within bound"}, 32'(mem_ready_o), 32'h1);
         void'(exp_q.pop_front());
         void'(lat_q.pop_front());
         mem_valid_i = 1'b0;
      end
      apb_bus.pready = 1'b0;
      chk({name, " setup cycles"},  32'(setup_n),  is_local ? 32'h0 : 32'h1);
      chk({name, " access cycles"}, 32'(access_n), is_local ? 32'h0 : 32'(exp_acc));
      @(negedge clk_i);
      chk({name, " ready one cycle"}, {30'b0, mem_ready_o, timeout_o}, 32'h0);
   endtask

   initial begin
      logic [31:0] r_addr;
      logic [31:0] r_data;
      int          r_wait;
      rst_i          = 1'b1;
      mem_valid_i    = 1'b0;
      mem_addr_i     = 32'h0;
      mem_wdata_i    = 32'h0;
      mem_wstrb_i    = 4'h0;
      apb_bus.pready = 1'b0;
      apb_bus.prdata = 32'h0;
      repeat (3) @(negedge clk_i);
      chk("reset ready",   32'(mem_ready_o), 32'h0);
      chk("reset rdata",   mem_rdata_o, 32'h0);
      chk("reset sel",     32'(sel_o), 32'h0);
      chk("reset timeout", 32'(timeout_o), 32'h0);
      chk("reset psel",    {30'b0, apb_bus.psel, apb_bus.penable}, 32'h0);
      chk("reset paddr",   apb_bus.paddr, 32'h0);
      chk("reset pwdata",  apb_bus.pwdata, 32'h0);
      chk("reset pstrb",   {27'b0, apb_bus.pwrite, apb_bus.pstrb}, 32'h0);
      rst_i = 1'b0;
      @(negedge clk_i);

      issue("apb_write", 32'h0000_0010, 32'hA5A5_0001, 4'hF, 0, 32'h0, 32'h0, 1, 1'b0, 1'b0, 1'b0);
      issue("apb_read_wait5", 32'h0000_0004, 32'h0, 4'h0, 5, 32'h1234_5678, 32'h1234_5678, 6, 1'b0, 1'b0, 1'b0);
      issue("local_write", 32'h0000_0FFC, 32'h0000_0001, 4'hF, 0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0);
      chk("sel after local write", 32'(sel_o), 32'h1);
      issue("local_read", 32'h0000_0FFC, 32'h0, 4'h0, 0, 32'h0, 32'h0000_0001, 0, 1'b1, 1'b0, 1'b0);
      // Byte 0 not strobed: select must not change even though the offset hits.
      issue("local_write_nobyte0", 32'h1234_5FFC, 32'h0000_0003, 4'h2, 0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0);
      chk("sel unchanged", 32'(sel_o), 32'h1);
      issue("apb_partial_write", 32'h0000_0100, 32'hCAFE_F00D, 4'h6, 2, 32'h0, 32'h0, 3, 1'b0, 1'b0, 1'b0);
      issue("apb_read_drop_valid", 32'h0000_0200, 32'h0, 4'h0, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 2, 1'b0, 1'b0, 1'b1);

      for (int k = 0; k < 4; k++) begin
         r_addr = $urandom & 32'hFFFF_FF00;
         r_data = $urandom;
         r_wait = $urandom_range(0, 3);
         if (k[0]) issue("rand_write", r_addr, r_data, 4'hF, r_wait, 32'h0, 32'h0, r_wait + 1, 1'b0, 1'b0, 1'b0);
         else      issue("rand_read", r_addr, 32'h0, 4'h0, r_wait, r_data, r_data, r_wait + 1, 1'b0, 1'b0, 1'b0);
      end

`ifdef USER_IP_BRIDGE_TIMEOUT_EN
      issue("timeout_stuck", 32'h0000_0300, 32'h0, 4'h0, 1000, 32'hFFFF_FFFF, 32'h0, TO_CYCLES, 1'b0, 1'b1, 1'b0);
      chk("psel after timeout", 32'(apb_bus.psel), 32'h0);
      issue("terminal_count_ready", 32'h0000_0304, 32'h0, 4'h0, TO_CYCLES - 1, 32'h5555_AAAA, 32'h5555_AAAA,
            TO_CYCLES, 1'b0, 1'b0, 1'b0);
`endif

      // Reset in the middle of ACCESS aborts the transfer silently.
      mem_valid_i = 1'b1;
      mem_addr_i  = 32'h0000_0020;
      mem_wdata_i = 32'h0;
      mem_wstrb_i = 4'h0;
      @(negedge clk_i);
      chk("abort setup ready", 32'(mem_ready_o), 32'h0);
      @(negedge clk_i);
      chk("abort in access", {30'b0, apb_bus.psel, apb_bus.penable}, 32'h3);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("abort psel", {30'b0, apb_bus.psel, apb_bus.penable}, 32'h0);
      chk("abort ready", 32'(mem_ready_o), 32'h0);
      chk("abort sel", 32'(sel_o), 32'h0);
      rst_i       = 1'b0;
      mem_valid_i = 1'b0;
      @(negedge clk_i);
      chk("abort no late ready", {30'b0, mem_ready_o, apb_bus.psel}, 32'h0);
      issue("after_reset_read", 32'h0000_0024, 32'h0, 4'h0, 0, 32'h7777_0001, 32'h7777_0001, 1, 1'b0, 1'b0, 1'b0);

      chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
